snake_score_display: RTL and testbench
======================================

Name: snake_score_display

Overview:
- Downstream consumer of the snake game core's Length and status flags.
- Converts the current snake length and a session high score to decimal and time-multiplexes them onto the 8-digit seven-segment display.
- Blinks the current score when the game is won or lost.
- Sits beside the VGA path in the top level and owns the An*/C*/Dp pins.

Parameters:
- LEN_W, 4, width of Length; legal range 1..6 (max value 63, two decimal digits).
- REFRESH_W, 18, width of the free-running scan counter; legal minimum 3.
- BLINK_W, 26, width of the free-running blink counter; legal minimum 1.

Ports:
- CLK  input  1  board clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Length  input  LEN_W  current snake length from the core, unsigned.
- Qw  input  1  core in win state.
- Ql  input  1  core in lose state.
- An  output  8  anode enables, active-low; An[7] drives An7.
- Ssd  output  8  segments {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.
- HiScore  output  LEN_W  registered high score, for LEDs or debug.

Behaviour:
- Reset (Reset_n=0, asynchronous) values:
  - An=8'hFF, Ssd=8'hFF, HiScore=0.
  - scan counter=0, blink counter=0.
  - On deassertion, operation resumes from count 0.
  - Reset asserted mid-scan blanks the display immediately.
- Scan counter:
  - Increments every CLK and wraps at 2^REFRESH_W-1 -> 0.
  - slot = scan[REFRESH_W-1:REFRESH_W-2].
  - Slot mapping: 0 -> An0 score ones; 1 -> An1 score tens; 2 -> An4 high-score ones; 3 -> An5 high-score tens.
  - Anodes not selected stay 1.
- Anti-ghosting: when scan[REFRESH_W-3:0]==0 (first cycle of each slot), registered An=8'hFF.
- Latency: An and Ssd are registered and reflect the counter value of the previous cycle (1-cycle latency).
- BCD conversion: tens = value/10, ones = value%10 (combinational). Both are computed from Length for the score digits and from HiScore for the high-score digits.
- Leading-zero suppression: if tens==0, the tens slot drives Ssd=8'hFF and its anode stays high.
- Segment codes, active-low, Dp always 1:
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
  - blank=11111111
- High score:
  - Each cycle, if Length > HiScore then HiScore <= Length (visible next cycle).
  - Never decreases; cleared only by Reset_n.
  - A drop in Length (new game) leaves HiScore unchanged.
- Blink:
  - Blink counter is free-running and wraps.
  - When (Qw|Ql)=1 and blink[BLINK_W-1]=1, score slots 0/1 drive An high and Ssd=8'hFF.
  - High-score slots are unaffected.
  - Qw and Ql both high is treated as blink.
  - Blink stops on the first cycle both are 0.
- Length is sampled every cycle with no input registering and no handshake. A change becomes visible at the next scan of the affected slot.

Test Plan (REFRESH_W=4, BLINK_W=3):
- Reset check: hold Reset_n=0 for 5 cycles with Length=7 -> An=8'hFF, Ssd=8'hFF, HiScore=0. Release -> HiScore=7 one cycle later.
- Full scan sweep: Length=12 after reset, HiScore=12, over 16 cycles ->
  - slot 0: An=8'b11111110, Ssd=00100101.
  - slot 1: An=8'b11111101, Ssd=10011111.
  - slot 2: An=8'b11101111.
  - slot 3: An=8'b11011111.
  - First cycle of each slot: An=8'hFF.
- Leading-zero suppression and high-score hold: Length=5 then 3 ->
  - slot 1 shows An=8'hFF, Ssd=8'hFF.
  - HiScore stays 5; slot 2 shows Ssd=01001001 while slot 0 shows 00001101.
- Blink: Length=9, Ql=1 ->
  - score slots are blank while blink[2]=1 and show 00001001 while blink[2]=0.
  - High-score slots are unaffected.
  - Drop Ql -> normal display within 1 cycle.
- Maximum value: LEN_W=6, Length=63 -> ones slot 00001101, tens slot 01000001, HiScore=63.
- Async reset mid-scan: assert Reset_n between clock edges during slot 2 -> An=8'hFF and HiScore=0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/snake_score_display.sv
// Seven-segment scoreboard for the snake core: current length on An1/An0, session high
// score on An5/An4, with the score digits blinking while the game is won or lost.
module snake_score_display #(
  parameter int LEN_W     = 4,
  parameter int REFRESH_W = 18,
  parameter int BLINK_W   = 26
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [LEN_W-1:0] Length,
  input  logic             Qw,
  input  logic             Ql,
  output logic [7:0]       An,
  output logic [7:0]       Ssd,
  output logic [LEN_W-1:0] HiScore
);

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = 8'b00000011;
      4'd1:    code = 8'b10011111;
      4'd2:    code = 8'b00100101;
      4'd3:    code = 8'b00001101;
      4'd4:    code = 8'b10011001;
      4'd5:    code = 8'b01001001;
      4'd6:    code = 8'b01000001;
      4'd7:    code = 8'b00011111;
      4'd8:    code = 8'b00000001;
      4'd9:    code = 8'b00001001;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  logic [REFRESH_W-1:0] scan;
  logic [BLINK_W-1:0]   blink;
  logic [7:0]           an_nxt;
  logic [7:0]           ssd_nxt;
  logic [1:0]           slot;
  logic                 slot_first;
  logic                 blink_off;

  // Values are at most 63, so a 7-bit working width covers every legal LEN_W.
  logic [6:0] score_val;
  logic [6:0] hi_val;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [3:0] hi_ones;
  logic [3:0] hi_tens;

  assign score_val  = 7'(Length);
  assign hi_val     = 7'(HiScore);
  assign score_ones = 4'(score_val % 7'd10);
  assign score_tens = 4'(score_val / 7'd10);
  assign hi_ones    = 4'(hi_val % 7'd10);
  assign hi_tens    = 4'(hi_val / 7'd10);

  assign slot       = scan[REFRESH_W-1:REFRESH_W-2];
  assign slot_first = (scan[REFRESH_W-3:0] == '0);
  assign blink_off  = (Qw | Ql) & blink[BLINK_W-1];

  always_comb begin
    an_nxt  = 8'hFF;
    ssd_nxt = SEG_BLANK;
    case (slot)
      2'd0: begin
        if (!blink_off) begin
          an_nxt  = 8'b11111110;
          ssd_nxt = seg_code(score_ones);
        end
      end
      2'd1: begin
        if (!blink_off && score_tens != 4'd0) begin
          an_nxt  = 8'b11111101;
          ssd_nxt = seg_code(score_tens);
        end
      end
      2'd2: begin
        an_nxt  = 8'b11101111;
        ssd_nxt = seg_code(hi_ones);
      end
      default: begin
        if (hi_tens != 4'd0) begin
          an_nxt  = 8'b11011111;
          ssd_nxt = seg_code(hi_tens);
        end
      end
    endcase
    // Keep all anodes off for one cycle at each slot change to avoid ghosting.
    if (slot_first) an_nxt = 8'hFF;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      scan    <= '0;
      blink   <= '0;
      An      <= 8'hFF;
      Ssd     <= SEG_BLANK;
      HiScore <= '0;
    end else begin
      scan  <= scan + 1'b1;
      blink <= blink + 1'b1;
      An    <= an_nxt;
      Ssd   <= ssd_nxt;
      if (Length > HiScore) HiScore <= Length;
    end
  end

endmodule

// File: tb/tb_snake_score_display.sv
// Scoreboard bench for snake_score_display: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against An/Ssd/HiScore.
module tb_snake_score_display;

  localparam int LEN_W     = 6;
  localparam int REFRESH_W = 4;
  localparam int BLINK_W   = 3;

  localparam logic [7:0] AN0 = 8'b11111110;
  localparam logic [7:0] AN1 = 8'b11111101;
  localparam logic [7:0] AN4 = 8'b11101111;
  localparam logic [7:0] AN5 = 8'b11011111;
  localparam logic [7:0] BL  = 8'hFF;
  localparam logic [7:0] S1  = 8'b10011111;
  localparam logic [7:0] S2  = 8'b00100101;
  localparam logic [7:0] S3  = 8'b00001101;
  localparam logic [7:0] S5  = 8'b01001001;
  localparam logic [7:0] S6  = 8'b01000001;
  localparam logic [7:0] S7  = 8'b00011111;
  localparam logic [7:0] S9  = 8'b00001001;

  logic             CLK = 1'b0;
  logic             Reset_n = 1'b0;
  logic [LEN_W-1:0] Length = '0;
  logic             Qw = 1'b0;
  logic             Ql = 1'b0;
  logic [7:0]       An;
  logic [7:0]       Ssd;
  logic [LEN_W-1:0] HiScore;

  snake_score_display #(
    .LEN_W(LEN_W), .REFRESH_W(REFRESH_W), .BLINK_W(BLINK_W)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Length(Length), .Qw(Qw), .Ql(Ql),
    .An(An), .Ssd(Ssd), .HiScore(HiScore)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string            name;
    logic [7:0]       an;
    logic [7:0]       ssd;
    bit               chk_ssd;
    logic [LEN_W-1:0] hi;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge CLK) begin : monitor
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (An !== e.an) begin
        n_fail++;
        $display("FAIL %s An: got %b expected %b @%0t", e.name, An, e.an, $time);
      end
      if (e.chk_ssd) begin
        n_checks++;
        if (Ssd !== e.ssd) begin
          n_fail++;
          $display("FAIL %s Ssd: got %b expected %b @%0t", e.name, Ssd, e.ssd, $time);
        end
      end
      n_checks++;
      if (HiScore !== e.hi) begin
        n_fail++;
        $display("FAIL %s HiScore: got %0d expected %0d @%0t", e.name, HiScore, e.hi, $time);
      end
    end
  end

  task automatic push_exp(input string name, input logic [7:0] an, input logic [7:0] ssd,
                          input bit chk, input logic [LEN_W-1:0] hi);
    exp_t e;
    e.name = name; e.an = an; e.ssd = ssd; e.chk_ssd = chk; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic cyc_raw(input string name, input logic [7:0] an, input logic [7:0] ssd,
                         input bit chk, input logic [LEN_W-1:0] hi);
    @(posedge CLK);
    #1;
    push_exp(name, an, ssd, chk, hi);
  endtask

  // c is the cycle index within a 4-cycle slot; cycle 0 is the anti-ghost blank.
  task automatic cyc_slot(input string name, input int c, input logic [7:0] an,
                          input logic [7:0] ssd, input logic [LEN_W-1:0] hi);
    cyc_raw(name, (c == 0) ? BL : an, ssd, (c != 0), hi);
  endtask

  // One full 16-cycle scan starting at scan=0; tables packed {slot3,slot2,slot1,slot0}.
  task automatic sweep(input string name, input logic [31:0] an4, input logic [31:0] ssd4,
                       input logic [LEN_W-1:0] hi);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++)
        cyc_slot(name, c, an4[s*8 +: 8], ssd4[s*8 +: 8], hi);
  endtask

  task automatic do_reset(input logic [LEN_W-1:0] len, input int cycles);
    @(negedge CLK);
    #1;
    Reset_n = 1'b0;
    Length  = len;
    Qw = 1'b0;
    Ql = 1'b0;
    for (int i = 0; i < cycles; i++) cyc_raw("reset", BL, BL, 1'b1, '0);
    Reset_n = 1'b1;
  endtask

  initial begin
    // Reset hold, then HiScore picks up Length one cycle after release.
    do_reset(6'd7, 5);
    sweep("len7", {BL, AN4, BL, AN0}, {BL, S7, BL, S7}, 6'd7);

    do_reset(6'd12, 2);
    sweep("len12", {AN5, AN4, AN1, AN0}, {S1, S2, S1, S2}, 6'd12);

    // Leading-zero suppression and high score held across a drop in Length.
    do_reset(6'd5, 2);
    sweep("len5", {BL, AN4, BL, AN0}, {BL, S5, BL, S5}, 6'd5);
    Length = 6'd3;
    sweep("drop3", {BL, AN4, BL, AN0}, {BL, S5, BL, S3}, 6'd5);

    // Blink: the blink MSB is low during slot 0 and high during slot 1 with these widths.
    do_reset(6'd9, 2);
    Ql = 1'b1;
    sweep("blink9", {BL, AN4, BL, AN0}, {BL, S9, BL, S9}, 6'd9);
    Length = 6'd19;
    sweep("blink19_ql", {AN5, AN4, BL, AN0}, {S1, S9, BL, S9}, 6'd19);
    Ql = 1'b0;
    Qw = 1'b1;
    sweep("blink19_qw", {AN5, AN4, BL, AN0}, {S1, S9, BL, S9}, 6'd19);
    Ql = 1'b0;
    Qw = 1'b0;
    sweep("noblink19", {AN5, AN4, AN1, AN0}, {S1, S9, S1, S9}, 6'd19);

    // Both flags high blink; dropping them restores slot 1 on the next cycle.
    Qw = 1'b1;
    Ql = 1'b1;
    for (int c = 0; c < 4; c++) cyc_slot("both_s0", c, AN0, S9, 6'd19);
    cyc_slot("both_s1", 0, BL, BL, 6'd19);
    cyc_slot("both_s1", 1, BL, BL, 6'd19);
    Qw = 1'b0;
    Ql = 1'b0;
    cyc_slot("unblink_s1", 2, AN1, S1, 6'd19);
    cyc_slot("unblink_s1", 3, AN1, S1, 6'd19);
    for (int c = 0; c < 4; c++) cyc_slot("unblink_s2", c, AN4, S9, 6'd19);
    for (int c = 0; c < 4; c++) cyc_slot("unblink_s3", c, AN5, S1, 6'd19);

    // Maximum 6-bit value.
    Length = 6'd63;
    sweep("max63", {AN5, AN4, AN1, AN0}, {S6, S3, S6, S3}, 6'd63);

    // Asynchronous reset between edges during slot 2.
    for (int c = 0; c < 4; c++) cyc_slot("pre_rst_s0", c, AN0, S3, 6'd63);
    for (int c = 0; c < 4; c++) cyc_slot("pre_rst_s1", c, AN1, S6, 6'd63);
    cyc_slot("pre_rst_s2", 0, AN4, S3, 6'd63);
    cyc_slot("pre_rst_s2", 1, AN4, S3, 6'd63);
    @(posedge CLK);
    #3;
    Reset_n = 1'b0;
    #1;
    push_exp("async_rst", BL, BL, 1'b1, '0);
    cyc_raw("async_rst_hold", BL, BL, 1'b1, '0);
    Reset_n = 1'b1;
    Length  = 6'd3;
    sweep("post_rst3", {BL, AN4, BL, AN0}, {BL, S3, BL, S3}, 6'd3);

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
